// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding, inverse S-box and GF(2^8) helpers
//
// Purpose : common definitions for the iterative AES inverse cipher.
// Contents: legal (nk,nr) pairs, FSM state encoding, inverse S-box table,
//           xtime / gmul over GF(2^8) with polynomial 0x11B.

package aes_pkg;

  localparam int aes128_nk = 4;
  localparam int aes128_nr = 10;
  localparam int aes192_nk = 6;
  localparam int aes192_nr = 12;
  localparam int aes256_nk = 8;
  localparam int aes256_nr = 14;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_round = 2'd1,
    st_last  = 2'd2
  } fsm_state_e;

  localparam logic [7:0] inv_sbox_tbl [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic legal_pair(input int nk, input int nr);
    return (nk == aes128_nk && nr == aes128_nr) ||
           (nk == aes192_nk && nr == aes192_nr) ||
           (nk == aes256_nk && nr == aes256_nr);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b it folds down to a few xtime/xor terms.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return inv_sbox_tbl[x];
  endfunction

endpackage

// File: rtl/decrypt_iter_round.sv
// rtl/decrypt_iter_round.sv - one combinational AES inverse round
//
// Purpose : nextState = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ roundKey),
//           with InvMixColumns bypassed when lastRound is set.
// Ports   : state     [0:127] in   current cipher state (bit 0 = MSB, column-major bytes)
//           roundKey  [0:127] in   round key to add
//           lastRound         in   1 = final round, skip InvMixColumns
//           nextState [0:127] out  resulting state

module decryptRound
  import aes_pkg::*;
(
  input  logic [0:127] state,
  input  logic [0:127] roundKey,
  input  logic         lastRound,
  output logic [0:127] nextState
);

  logic [7:0] keyed [0:15];
  logic [7:0] mixed [0:15];

  always_comb begin
    for (int b = 0; b < 16; b++) begin
      keyed[b] = 8'h00;
      mixed[b] = 8'h00;
    end
    nextState = '0;

    // Byte b sits at row b%4, column b/4. InvShiftRows rotates row r right by r,
    // so output (r,c) takes the input byte from column (c - r) mod 4.
    for (int b = 0; b < 16; b++) begin
      int r;
      int c;
      int src;
      r   = b % 4;
      c   = b / 4;
      src = r + 4 * ((c + 4 - r) % 4);
      keyed[b] = inv_sbox(state[8*src +: 8]) ^ roundKey[8*b +: 8];
    end

    for (int c = 0; c < 4; c++) begin
      mixed[4*c+0] = gmul(keyed[4*c+0], 8'h0e) ^ gmul(keyed[4*c+1], 8'h0b) ^
                     gmul(keyed[4*c+2], 8'h0d) ^ gmul(keyed[4*c+3], 8'h09);
      mixed[4*c+1] = gmul(keyed[4*c+0], 8'h09) ^ gmul(keyed[4*c+1], 8'h0e) ^
                     gmul(keyed[4*c+2], 8'h0b) ^ gmul(keyed[4*c+3], 8'h0d);
      mixed[4*c+2] = gmul(keyed[4*c+0], 8'h0d) ^ gmul(keyed[4*c+1], 8'h09) ^
                     gmul(keyed[4*c+2], 8'h0e) ^ gmul(keyed[4*c+3], 8'h0b);
      mixed[4*c+3] = gmul(keyed[4*c+0], 8'h0b) ^ gmul(keyed[4*c+1], 8'h0d) ^
                     gmul(keyed[4*c+2], 8'h09) ^ gmul(keyed[4*c+3], 8'h0e);
    end

    for (int b = 0; b < 16; b++) begin
      nextState[8*b +: 8] = lastRound ? keyed[b] : mixed[b];
    end
  end

endmodule

// File: rtl/decrypt_iter.sv
// rtl/decrypt_iter.sv - iterative AES inverse cipher, one round per clock
//
// Purpose : decrypts one 128-bit block using a precomputed key schedule.
// Params  : nk  key length in 32-bit words (4/6/8)
//           nr  number of rounds (10/12/14, paired with nk)
// Ports   : clk                          clock, posedge
//           reset                        asynchronous active-low reset
//           start                        request, sampled only while idle
//           cipher      [0:127]          ciphertext, captured on the accepted start edge
//           keySchedule [0:128*(nr+1)-1] round key r at [128*r +: 128]
//           message     [0:127]          plaintext, held until the next completion
//           busy                         high from the cycle after start until done
//           done                         one-cycle completion pulse

module decrypt_iter
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [0:127]            cipher,
  input  logic [0:128*(nr+1)-1]   keySchedule,
  output logic [0:127]            message,
  output logic                    busy,
  output logic                    done
);

  if (!legal_pair(nk, nr)) begin : g_bad_params
    $error("decrypt_iter: illegal (nk,nr) pairing");
  end

  localparam logic [3:0] rnd_init    = 4'(nr - 1);
  localparam int         rk_nr_base  = 128 * nr;

  fsm_state_e   fsm;
  logic [3:0]   rnd;
  logic [0:127] state_q;

  logic [3:0]   rk_index;
  logic [10:0]  rk_base;
  logic [0:127] round_key;
  logic [0:127] first_key;
  logic [0:127] round_out;
  logic         last_round;

  // One round datapath serves both ROUND and LAST; only the key select differs.
  assign last_round = (fsm == st_last);
  assign rk_index   = last_round ? 4'd0 : rnd;
  assign rk_base    = {rk_index, 7'd0};
  assign round_key  = keySchedule[rk_base +: 128];
  assign first_key  = keySchedule[rk_nr_base +: 128];

  decryptRound u_round (
    .state     (state_q),
    .roundKey  (round_key),
    .lastRound (last_round),
    .nextState (round_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm     <= st_idle;
      rnd     <= 4'd0;
      state_q <= '0;
      message <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        st_idle: begin
          if (start) begin
            state_q <= cipher ^ first_key;
            rnd     <= rnd_init;
            busy    <= 1'b1;
            fsm     <= (rnd_init == 4'd0) ? st_last : st_round;
          end
        end
        st_round: begin
          state_q <= round_out;
          // Stops at 0 after the rnd==1 round; LAST never reads rnd.
          rnd     <= rnd - 4'd1;
          if (rnd == 4'd1) fsm <= st_last;
        end
        st_last: begin
          message <= round_out;
          done    <= 1'b1;
          busy    <= 1'b0;
          fsm     <= st_idle;
        end
        default: begin
          fsm  <= st_idle;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_iter.sv
// tb/tb_decrypt_iter.sv - directed self-checking bench for decrypt_iter

module tb_decrypt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          start0, start1, start2;
  logic [0:127]  cipher0, cipher1, cipher2;
  logic [0:1407] ks0;
  logic [0:1663] ks1;
  logic [0:1919] ks2;
  logic [0:127]  message0, message1, message2;
  logic          busy0, busy1, busy2;
  logic          done0, done1, done2;

  int tests = 0;
  int fails = 0;

  localparam logic [0:127] plain_a  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] cipher_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] cipher_c = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] cipher_d = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] plain_b  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [0:127] cipher_b = 128'h29c3505f571420f6402299b31a02d73a;

  logic [0:1407] ks_a;
  logic [0:1407] ks_b;

  decrypt_iter #(.nk(4), .nr(10)) u_dut128 (
    .clk(clk), .reset(reset), .start(start0), .cipher(cipher0), .keySchedule(ks0),
    .message(message0), .busy(busy0), .done(done0));

  decrypt_iter #(.nk(6), .nr(12)) u_dut192 (
    .clk(clk), .reset(reset), .start(start1), .cipher(cipher1), .keySchedule(ks1),
    .message(message1), .busy(busy1), .done(done1));

  decrypt_iter #(.nk(8), .nr(14)) u_dut256 (
    .clk(clk), .reset(reset), .start(start2), .cipher(cipher2), .keySchedule(ks2),
    .message(message2), .busy(busy2), .done(done2));

  // keySchedule must not move while the 128-bit core is busy.
  logic [0:1407] ks0_prev;
  always @(posedge clk) begin
    if (busy0) begin
      assert (ks0 === ks0_prev)
        else $error("FAIL ks_stable: keySchedule changed while busy");
    end
    ks0_prev <= ks0;
  end

  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = tb_xtime(aa);
    end
    return p;
  endfunction

  // Forward S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] tb_subword(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk, input int nr);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1919] ks;
    ks   = '0;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = tb_subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = tb_xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = tb_subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  // Pulse start on the 128-bit core and wait for done; lat stays -1 on timeout.
  task automatic run128(input logic [0:127] c, output int lat, output logic [0:127] msg);
    @(negedge clk);
    start0  = 1'b1;
    cipher0 = c;
    @(negedge clk);
    start0  = 1'b0;
    cipher0 = '0;
    lat = -1;
    msg = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done0) begin
        lat = i;
        msg = message0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests += 9;
    if (busy0 !== 1'b0)     begin fails++; $display("FAIL rst_busy0: got %b want 0", busy0); end
    if (done0 !== 1'b0)     begin fails++; $display("FAIL rst_done0: got %b want 0", done0); end
    if (message0 !== '0)    begin fails++; $display("FAIL rst_msg0: got %h want 0", message0); end
    if (busy1 !== 1'b0)     begin fails++; $display("FAIL rst_busy1: got %b want 0", busy1); end
    if (done1 !== 1'b0)     begin fails++; $display("FAIL rst_done1: got %b want 0", done1); end
    if (message1 !== '0)    begin fails++; $display("FAIL rst_msg1: got %h want 0", message1); end
    if (busy2 !== 1'b0)     begin fails++; $display("FAIL rst_busy2: got %b want 0", busy2); end
    if (done2 !== 1'b0)     begin fails++; $display("FAIL rst_done2: got %b want 0", done2); end
    if (message2 !== '0)    begin fails++; $display("FAIL rst_msg2: got %h want 0", message2); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aes128();
    int lat;
    logic seen_busy;
    logic busy_at_done;
    lat = -1;
    seen_busy = 1'b0;
    busy_at_done = 1'b1;
    @(negedge clk);
    start0  = 1'b1;
    cipher0 = cipher_a;
    @(negedge clk);
    start0  = 1'b0;
    seen_busy = busy0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done0) begin
        lat = i;
        busy_at_done = busy0;
        break;
      end
    end
    tests += 4;
    if (seen_busy !== 1'b1)    begin fails++; $display("FAIL aes128_busy: got %b want 1", seen_busy); end
    if (lat != 10)             begin fails++; $display("FAIL aes128_latency: got %0d want 10", lat); end
    if (message0 !== plain_a)  begin fails++; $display("FAIL aes128_msg: got %h want %h", message0, plain_a); end
    if (busy_at_done !== 1'b0) begin fails++; $display("FAIL aes128_busy_done: got %b want 0", busy_at_done); end
  endtask

  task automatic test_aes192();
    int lat;
    lat = -1;
    @(negedge clk);
    start1  = 1'b1;
    cipher1 = cipher_c;
    @(negedge clk);
    start1  = 1'b0;
    cipher1 = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done1) begin lat = i; break; end
    end
    tests += 2;
    if (lat != 12)            begin fails++; $display("FAIL aes192_latency: got %0d want 12", lat); end
    if (message1 !== plain_a) begin fails++; $display("FAIL aes192_msg: got %h want %h", message1, plain_a); end
  endtask

  task automatic test_aes256();
    int lat;
    lat = -1;
    @(negedge clk);
    start2  = 1'b1;
    cipher2 = cipher_d;
    @(negedge clk);
    start2  = 1'b0;
    cipher2 = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done2) begin lat = i; break; end
    end
    tests += 2;
    if (lat != 14)            begin fails++; $display("FAIL aes256_latency: got %0d want 14", lat); end
    if (message2 !== plain_a) begin fails++; $display("FAIL aes256_msg: got %h want %h", message2, plain_a); end
  endtask

  task automatic test_ignore_start();
    int lat;
    int dones;
    lat = -1;
    dones = 0;
    @(negedge clk);
    ks0 = ks_b;
    @(negedge clk);
    start0  = 1'b1;
    cipher0 = cipher_b;
    @(negedge clk);
    start0  = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4) begin start0 = 1'b1; cipher0 = cipher_a; end
      if (i == 5) start0 = 1'b0;
      if (done0) begin
        dones++;
        if (lat < 0) lat = i;
      end
    end
    tests += 3;
    if (dones != 1)           begin fails++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    if (lat != 10)            begin fails++; $display("FAIL ignore_latency: got %0d want 10", lat); end
    if (message0 !== plain_b) begin fails++; $display("FAIL ignore_msg: got %h want %h", message0, plain_b); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [0:127] msg;
    @(negedge clk);
    ks0 = ks_a;
    @(negedge clk);
    start0  = 1'b1;
    cipher0 = cipher_a;
    @(negedge clk);
    start0  = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    tests += 3;
    if (busy0 !== 1'b0)  begin fails++; $display("FAIL midrst_busy: got %b want 0", busy0); end
    if (done0 !== 1'b0)  begin fails++; $display("FAIL midrst_done: got %b want 0", done0); end
    if (message0 !== '0) begin fails++; $display("FAIL midrst_msg: got %h want 0", message0); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run128(cipher_a, lat, msg);
    tests += 2;
    if (lat != 10)       begin fails++; $display("FAIL midrst_rerun_latency: got %0d want 10", lat); end
    if (msg !== plain_a) begin fails++; $display("FAIL midrst_rerun_msg: got %h want %h", msg, plain_a); end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    logic [0:127] msg1;
    logic hold_bad;
    logic busy_after;
    lat1 = -1;
    lat2 = -1;
    msg1 = '0;
    hold_bad = 1'b0;
    busy_after = 1'b0;
    @(negedge clk);
    start0  = 1'b1;
    cipher0 = cipher_a;
    @(negedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done0) begin lat1 = i; msg1 = message0; break; end
    end
    // Start stays high; swap in the second vector for the edge that follows done.
    cipher0 = cipher_b;
    ks0     = ks_b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) busy_after = busy0 & ~done0;
      if (done0) begin lat2 = i; break; end
      if (message0 !== plain_a) hold_bad = 1'b1;
    end
    start0 = 1'b0;
    tests += 6;
    if (lat1 != 10)           begin fails++; $display("FAIL b2b_latency1: got %0d want 10", lat1); end
    if (msg1 !== plain_a)     begin fails++; $display("FAIL b2b_msg1: got %h want %h", msg1, plain_a); end
    if (busy_after !== 1'b1)  begin fails++; $display("FAIL b2b_restart_busy: got %b want 1", busy_after); end
    if (hold_bad !== 1'b0)    begin fails++; $display("FAIL b2b_msg_hold: got %b want 0", hold_bad); end
    if (lat2 != 11)           begin fails++; $display("FAIL b2b_latency2: got %0d want 11", lat2); end
    if (message0 !== plain_b) begin fails++; $display("FAIL b2b_msg2: got %h want %h", message0, plain_b); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:1919] full;
    reset   = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    start2  = 1'b0;
    cipher0 = '0;
    cipher1 = '0;
    cipher2 = '0;

    full = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    ks_a = full[0:1407];
    full = expand_key({128'h5468617473206d79204b756e67204675, 128'h0}, 4, 10);
    ks_b = full[0:1407];
    full = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    ks1  = full[0:1663];
    full = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    ks2  = full;
    ks0  = ks_a;

    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
